// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the arbitrated UART transmitter.
package uart_pkg;

    localparam int CLK_DIV_DEF = 10416;
    localparam int FRAME_BITS  = 10;
    localparam int CNT_W       = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle: requests and bytes in, acks and line status out.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] din;
    logic [NREQ-1:0]   ack;
    logic              tx;
    logic              busy;
    logic [2:0]        gnt_id;

    modport master (
        output req, din,
        input  ack, tx, busy, gnt_id
    );

    modport slave (
        input  req, din,
        output ack, tx, busy, gnt_id
    );
endinterface

// File: rtl/uart_tx_core.sv
// 8N1 serializer: bit-period counter, shift register and registered tx line.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       done,
    output logic       tx,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sh_q, sh_d;
    logic             tx_q, tx_d;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    // The counter only runs inside a frame and restarts at every bit edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                tx_d  = 1'b1;
                if (start) begin
                    state_d = ST_START;
                    sh_d    = byte_in;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = sh_q[0];
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            ST_STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART serializer; the last grantee
// gets lowest priority on the next search.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int NREQ    = 4
) (
    input  logic            clk,
    input  logic            nrst,
    uart_tx_arbiter_if.slave bus
);

    logic [2:0]  gnt_q, gnt_d;
    logic        pend_q, pend_d;
    logic [7:0]  req_ext;
    logic [63:0] din_ext;
    logic [7:0]  one_hot;
    logic [7:0]  byte_sel;
    logic [3:0]  j;
    logic [2:0]  sel;
    logic        found;
    logic        start;
    logic        done;
    logic        core_busy;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            gnt_q  <= 3'(NREQ - 1);
            pend_q <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            pend_q <= pend_d;
        end
    end

    // Search gnt+1 .. gnt (mod NREQ); first asserted request wins.
    always_comb begin
        req_ext = 8'(bus.req);
        din_ext = 64'(bus.din);
        sel     = gnt_q;
        found   = 1'b0;
        j       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = {1'b0, gnt_q} + 4'(k);
            if (j >= 4'(NREQ)) j = j - 4'(NREQ);
            if (!found && req_ext[j[2:0]]) begin
                found = 1'b1;
                sel   = j[2:0];
            end
        end
        start    = nrst && !pend_q && found;
        one_hot  = 8'd1 << sel;
        byte_sel = 8'(din_ext >> {sel, 3'b000});
        gnt_d    = start ? sel : gnt_q;
        pend_d   = pend_q;
        if (start)     pend_d = 1'b1;
        else if (done) pend_d = 1'b0;
    end

    assign bus.ack    = start ? one_hot[NREQ-1:0] : '0;
    assign bus.gnt_id = gnt_q;
    assign bus.busy   = core_busy;

    uart_tx_core #(
        .CLK_DIV (CLK_DIV)
    ) u_core (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .byte_in (byte_sel),
        .done    (done),
        .tx      (bus.tx),
        .busy    (core_busy)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at CLK_DIV=4, NREQ=4.
module tb_uart_tx_arbiter;

    localparam int DIV = 4;
    localparam int NR  = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   errs = 0;
    int   checks = 0;

    uart_tx_arbiter_if #(.NREQ(NR)) bus ();

    uart_tx_arbiter #(
        .CLK_DIV (DIV),
        .NREQ    (NR)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] r);
        @(posedge clk) #1;
        nrst    = 1'b0;
        bus.req = r;
        repeat (2) @(negedge clk);
        chk("rst_ack", 64'(bus.ack), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk) #1;
        nrst = 1'b1;
    endtask

    task automatic wait_ack(input int idx, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack == '0 && n < 200);
        chk({tag, "_ack"}, 64'(bus.ack), 64'(4'b0001 << idx));
        chk({tag, "_busy_at_grant"}, 64'(bus.busy), 64'd0);
        chk({tag, "_tx_at_grant"}, 64'(bus.tx), 64'd1);
    endtask

    // Samples the 40 frame cycles after the grant cycle.
    task automatic rx_frame(input logic [7:0] b, input int gid,
                            input string tag, input int pulse_at,
                            input logic [3:0] pmask);
        logic [39:0] got_tx, exp_tx, got_busy;
        logic        ack_any;
        ack_any = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            got_tx[c]   = bus.tx;
            got_busy[c] = bus.busy;
            ack_any     = ack_any | (|bus.ack);
            if (c < 4)        exp_tx[c] = 1'b0;
            else if (c >= 36) exp_tx[c] = 1'b1;
            else              exp_tx[c] = b[c/4 - 1];
            if (c == pulse_at) begin
                @(posedge clk) #1;
                bus.req = pmask;
            end
            if (c == pulse_at + 1) begin
                @(posedge clk) #1;
                bus.req = '0;
            end
        end
        chk({tag, "_tx"}, 64'(got_tx), 64'(exp_tx));
        chk({tag, "_busy"}, 64'(got_busy), {24'd0, {40{1'b1}}});
        chk({tag, "_no_ack"}, 64'(ack_any), 64'd0);
        chk({tag, "_gnt"}, 64'(bus.gnt_id), 64'(gid));
    endtask

    task automatic idle_chk(input string tag, input int cyc);
        logic ack_any, tx_all, busy_any;
        ack_any  = 1'b0;
        tx_all   = 1'b1;
        busy_any = 1'b0;
        for (int c = 0; c < cyc; c++) begin
            @(negedge clk);
            ack_any  = ack_any | (|bus.ack);
            tx_all   = tx_all & bus.tx;
            busy_any = busy_any | bus.busy;
        end
        chk({tag, "_ack"}, 64'(ack_any), 64'd0);
        chk({tag, "_tx"}, 64'(tx_all), 64'd1);
        chk({tag, "_busy"}, 64'(busy_any), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int id;
        bus.req = '0;
        bus.din = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_tx", 64'(bus.tx), 64'd1);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_ack", 64'(bus.ack), 64'd0);
        chk("reset_gnt", 64'(bus.gnt_id), 64'd3);
        @(posedge clk) #1;
        nrst = 1'b1;
        idle_chk("idle0", 5);

        // single request, 0x55
        @(posedge clk) #1;
        bus.req = 4'b0001;
        bus.din = 32'h0000_0055;
        wait_ack(0, "single", n);
        chk("single_lat", 64'(n), 64'd1);
        @(posedge clk) #1;
        bus.req = '0;
        bus.din = 32'hFFFF_FFAA;
        rx_frame(8'h55, 0, "single", -10, 4'b0000);
        idle_chk("idle1", 6);

        // all four requesting: order 0,1,2,3,0 and 41-cycle spacing
        bus.din = 32'hA3A2_A1A0;
        do_reset(4'b1111);
        for (int i = 0; i < 5; i++) begin
            id = i % 4;
            wait_ack(id, $sformatf("rr%0d", i), n);
            chk($sformatf("rr%0d_gap", i), 64'(n), 64'd1);
            rx_frame(8'hA0 + 8'(id), id, $sformatf("rr%0d", i), -10, 4'b0000);
        end
        @(posedge clk) #1;
        bus.req = '0;
        idle_chk("idle2", 4);

        // fairness between 1 and 3
        bus.din = 32'hB300_B100;
        do_reset(4'b1010);
        for (int i = 0; i < 4; i++) begin
            id = (i % 2 == 0) ? 1 : 3;
            wait_ack(id, $sformatf("fair%0d", i), n);
            chk($sformatf("fair%0d_gap", i), 64'(n), 64'd1);
            rx_frame((id == 1) ? 8'hB1 : 8'hB3, id,
                     $sformatf("fair%0d", i), -10, 4'b0000);
        end
        @(posedge clk) #1;
        bus.req = '0;
        idle_chk("idle3", 4);

        // withdrawal: req[2] pulsed mid-frame gets nothing
        bus.din = 32'h0000_003C;
        do_reset(4'b0000);
        @(posedge clk) #1;
        bus.req = 4'b0001;
        wait_ack(0, "wd", n);
        @(posedge clk) #1;
        bus.req = '0;
        rx_frame(8'h3C, 0, "wd", 10, 4'b0100);
        idle_chk("wd_idle", 10);
        chk("wd_gnt", 64'(bus.gnt_id), 64'd0);

        // reset in data bit 3 of a 0xFF frame
        bus.din = 32'h0000_00FF;
        do_reset(4'b0000);
        @(posedge clk) #1;
        bus.req = 4'b0001;
        wait_ack(0, "mid", n);
        @(posedge clk) #1;
        bus.req = '0;
        repeat (17) @(negedge clk);
        chk("mid_busy_before", 64'(bus.busy), 64'd1);
        @(posedge clk) #1;
        nrst    = 1'b0;
        bus.req = 4'b1111;
        @(negedge clk);
        chk("mid_ack_in_rst", 64'(bus.ack), 64'd0);
        @(negedge clk);
        chk("mid_tx_after", 64'(bus.tx), 64'd1);
        chk("mid_busy_after", 64'(bus.busy), 64'd0);
        chk("mid_ack_after", 64'(bus.ack), 64'd0);
        chk("mid_gnt_after", 64'(bus.gnt_id), 64'd3);
        @(posedge clk) #1;
        nrst = 1'b1;
        wait_ack(0, "post", n);
        chk("post_lat", 64'(n), 64'd1);
        @(posedge clk) #1;
        bus.req = '0;
        rx_frame(8'hFF, 0, "post", -10, 4'b0000);
        idle_chk("idle4", 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
